// File: rtl/alu_operand_seq_if.sv
// alu_operand_seq_if: command, ALU operand/result and result-handshake bundle for alu_operand_seq.
interface alu_operand_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load;
    logic [3:0]  cmd_sel;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_c;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
    logic        busy;
    modport master (
        output cmd_valid, cmd_load, cmd_sel, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, alu_c, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_rd, busy
    );
    modport slave (
        input  cmd_valid, cmd_load, cmd_sel, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, alu_c, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_rd, busy
    );
endinterface

// File: rtl/alu_operand_seq.sv
// alu_operand_seq: FIFO-buffered command sequencer driving a 32-bit ALU with an 8x32 register file.
// Define ALU_SEQ_OVERLAP_EN to pop the next command on the result handshake (2-cycle throughput).
module alu_operand_seq #(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    alu_operand_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic        load;
        logic [3:0]  sel;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [31:0] imm;
    } cmd_t;
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t        r_state;
    cmd_t          r_fifo [DEPTH];
    cmd_t          r_cmd;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_rf [8];
    logic [31:0]   r_res_data;
    logic [2:0]    r_res_rd;
    logic          w_push;
    logic          w_pop;
    logic          w_hs;
    logic          w_exec;
    logic [31:0]   w_result;
    assign w_exec = r_state == EXEC;
    assign w_hs = r_state == WB && bus.res_ready;
    assign w_push = bus.cmd_valid && bus.cmd_ready;
`ifdef ALU_SEQ_OVERLAP_EN
    assign w_pop = r_count != '0 && (r_state == IDLE || w_hs);
`else
    assign w_pop = r_count != '0 && r_state == IDLE;
`endif
    assign w_result = r_cmd.load ? r_cmd.imm : bus.alu_c;
    assign bus.cmd_ready = r_count != (AW+1)'(DEPTH);
    assign bus.alu_a = w_exec ? r_rf[r_cmd.rs1] : '0;
    assign bus.alu_b = w_exec ? r_rf[r_cmd.rs2] : '0;
    assign bus.alu_sel = w_exec ? r_cmd.sel : '0;
    assign bus.res_valid = r_state == WB;
    assign bus.res_data = r_res_data;
    assign bus.res_rd = r_res_rd;
    assign bus.busy = r_state != IDLE || r_count != '0;
    // Queue storage needs no reset: count and pointers alone define what is valid.
    always_ff @(posedge clk)
        if (w_push) r_fifo[r_wr_ptr] <= '{bus.cmd_load, bus.cmd_sel, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2, bus.cmd_imm};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state    <= IDLE;
            r_cmd      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_res_data <= '0;
            r_res_rd   <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cmd    <= r_fifo[r_rd_ptr];
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            case (r_state)
                IDLE: if (w_pop) r_state <= EXEC;
                EXEC: begin
                    r_res_data       <= w_result;
                    r_res_rd         <= r_cmd.rd;
                    r_rf[r_cmd.rd]   <= w_result;
                    r_state          <= WB;
                end
                default: if (w_hs) r_state <= w_pop ? EXEC : IDLE;
            endcase
        end
endmodule

// File: tb/tb_alu_operand_seq.sv
// tb_alu_operand_seq: directed bench with an in-order result model for alu_operand_seq.
`timescale 1ns/1ps
module tb_alu_operand_seq;
`ifdef ALU_SEQ_OVERLAP_EN
    localparam int PERIOD = 2;
`else
    localparam int PERIOD = 3;
`endif
    typedef struct {
        logic [2:0]  rd;
        logic [31:0] data;
    } res_t;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    res_t exp_q[$];
    logic [31:0] rf_m [8];
    int rises[$];
    logic prev_v = 0;
    alu_operand_seq_if bus();
    alu_operand_seq #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a ^ b;
            4'h4: return a + b;
            4'h5: return a - b;
            4'h6: return a << b[4:0];
            4'h7: return a >> b[4:0];
            default: return ~(a ^ b) + {28'd0, s};
        endcase
    endfunction
    assign bus.alu_c = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // In-order model: each accepted command's result is fixed by the register state at acceptance.
    always @(posedge clk or posedge rst)
        if (rst) begin
            exp_q.delete();
            foreach (rf_m[i]) rf_m[i] = '0;
        end else begin
            if (bus.res_valid && bus.res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.cmd_valid && bus.cmd_ready) begin
                logic [31:0] r;
                r = bus.cmd_load ? bus.cmd_imm : alu_fn(bus.cmd_sel, rf_m[bus.cmd_rs1], rf_m[bus.cmd_rs2]);
                rf_m[bus.cmd_rd] = r;
                exp_q.push_back('{bus.cmd_rd, r});
            end
        end
    always @(negedge clk)
        if (!rst) begin
            if (bus.res_valid) begin
                if (exp_q.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
                else begin
                    chk("res_data", bus.res_data, exp_q[0].data);
                    chk("res_rd", {29'd0, bus.res_rd}, {29'd0, exp_q[0].rd});
                    chk("alu_sel_wb", {28'd0, bus.alu_sel}, 32'd0);
                end
            end else if (!bus.busy) chk("idle_drained", exp_q.size(), 32'd0);
        end
    always @(negedge clk) begin
        if (bus.res_valid && !prev_v) rises.push_back(cyc);
        prev_v = bus.res_valid;
    end
    task automatic send(input logic ld, input logic [3:0] sel, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm);
        int n = 0;
        bus.cmd_load = ld; bus.cmd_sel = sel; bus.cmd_rd = rd;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm; bus.cmd_valid = 1;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 0;
    endtask
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask
    initial begin
        int acc;
        int n;
        logic rdy;
        bus.cmd_valid = 0; bus.cmd_load = 0; bus.cmd_sel = 0; bus.cmd_rd = 0;
        bus.cmd_rs1 = 0; bus.cmd_rs2 = 0; bus.cmd_imm = 0; bus.res_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        rst = 0;
        @(negedge clk);
        // Load and add, with per-cycle latency after the accepting edge
        send(1, 0, 1, 0, 0, 32'hA);
        send(1, 0, 2, 0, 0, 32'h3);
        wait_idle();
        send(0, 4'b0100, 3, 1, 2, 0);
        @(negedge clk);
        chk("lat_c1_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("lat_c1_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("exec_alu_a", bus.alu_a, 32'hA);
        chk("exec_alu_b", bus.alu_b, 32'h3);
        chk("exec_alu_sel", {28'd0, bus.alu_sel}, 32'd4);
        @(negedge clk);
        chk("lat_c3_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("add_data", bus.res_data, 32'hD);
        chk("add_rd", {29'd0, bus.res_rd}, 32'd3);
        wait_idle();
        // Subtract wrap, then read back through the written register
        send(1, 0, 1, 0, 0, 32'h0);
        send(1, 0, 2, 0, 0, 32'h1);
        send(0, 4'b0101, 4, 1, 2, 0);
        send(0, 4'b0001, 5, 4, 0, 0);
        wait_idle();
        chk("wb_readback", bus.res_data, 32'hFFFF_FFFF);
        chk("wb_readback_rd", {29'd0, bus.res_rd}, 32'd5);
        // Backpressure
        bus.res_ready = 0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cmd_load = 1; bus.cmd_rd = 3'(i); bus.cmd_imm = 32'(100 + i); bus.cmd_valid = 1;
            rdy = bus.cmd_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        bus.cmd_valid = 0;
        chk("bp_accepted", acc, 32'd5);
        chk("bp_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_data", bus.res_data, 32'd100);
        end
        bus.res_ready = 1;
        @(negedge clk);
        bus.res_ready = 0;
        n = 0;
        while (!bus.cmd_ready && n < 4) begin @(negedge clk); n++; end
        chk("bp_slot_freed", {31'd0, bus.cmd_ready}, 32'd1);
        bus.res_ready = 1;
        wait_idle();
        // Reset during EXEC with three commands queued
        bus.res_ready = 0;
        send(0, 4'b0100, 6, 1, 2, 0);
        n = 0;
        while (!bus.res_valid && n < 10) begin @(negedge clk); n++; end
        repeat (4) send(0, 4'b0100, 6, 1, 2, 0);
        @(negedge clk);
        bus.res_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.alu_sel != 4'b0100 && n < 10);
        chk("rst_pre_exec", {28'd0, bus.alu_sel}, 32'd4);
        rst = 1;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("mid_rst_alu_a", bus.alu_a, 32'd0);
        chk("mid_rst_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
        chk("mid_rst_res_data", bus.res_data, 32'd0);
        @(negedge clk);
        rst = 0;
        chk("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        send(0, 4'b0001, 6, 1, 2, 0);
        wait_idle();
        chk("rf_cleared", bus.res_data, 32'd0);
        // Throughput: dependent chain r7 += r1 issued back to back
        send(1, 0, 1, 0, 0, 32'd5);
        wait_idle();
        rises.delete();
        repeat (4) send(0, 4'b0100, 7, 7, 1, 0);
        wait_idle();
        chk("tp_count", rises.size(), 32'd4);
        if (rises.size() == 4)
            for (int i = 1; i < 4; i++) chk("tp_gap", rises[i] - rises[i-1], PERIOD);
        chk("tp_last", bus.res_data, 32'd20);
        // Push coinciding with a pop at count 3
        bus.res_ready = 0;
        for (int i = 0; i < 4; i++) send(1, 0, 3'(i), 0, 0, 32'h200 + i);
        @(negedge clk);
        chk("pp_ready_cnt3", {31'd0, bus.cmd_ready}, 32'd1);
        bus.res_ready = 1;
`ifdef ALU_SEQ_OVERLAP_EN
        send(1, 0, 4, 0, 0, 32'h204);
        bus.res_ready = 0;
`else
        @(posedge clk);
        #1 bus.res_ready = 0;
        @(negedge clk);
        send(1, 0, 4, 0, 0, 32'h204);
`endif
        @(negedge clk);
        chk("pp_ready_kept", {31'd0, bus.cmd_ready}, 32'd1);
        send(1, 0, 5, 0, 0, 32'h205);
        @(negedge clk);
        chk("pp_full", {31'd0, bus.cmd_ready}, 32'd0);
        bus.res_ready = 1;
        wait_idle();
        chk("pp_last", bus.res_data, 32'h205);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
